axis_sym_unpack: RTL

//  Generalised word-to-symbol unpacker for the QPSK modulator chain. Splits each IN_W-bit
//  AXI-Stream word into IN_W/SYM_W symbols and emits each symbol cfg_sps times, one per beat.

---
 rtl/axis_sym_unpack_pkg.sv | 12 +
 rtl/axis_sym_unpack.sv | 127 ++++++++++++
 2 files changed

// File: rtl/axis_sym_unpack_pkg.sv
// Shared types and helpers for the AXI-Stream word-to-symbol unpacker.
package sym_unpack_pkg;

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam int SPS_MIN = 1;

    function automatic int nsym(input int in_w, input int sym_w);
        return in_w / sym_w;
    endfunction

endpackage

// File: rtl/axis_sym_unpack.sv
// Splits each AXIS word into SYM_W-bit symbols, repeating each symbol sps times.
// Output beat, last flag and valid all come straight from flops.
module axis_sym_unpack
    import sym_unpack_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int SYM_W     = 2,
    parameter int OUT_W     = 32,
    parameter int SPS_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             axis_data_clk,
    input  logic             axis_data_rst_n,
    input  logic [SPS_W-1:0] cfg_sps,
    input  logic             cfg_msb_first,
    input  logic [IN_W-1:0]  s_tdata,
    input  logic             s_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [OUT_W-1:0] m_tdata,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             busy
);

    localparam int NSYM  = nsym(IN_W, SYM_W);
    localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

    if (IN_W % SYM_W != 0) begin : g_bad_in_w
        $error("axis_sym_unpack: IN_W must be a multiple of SYM_W");
    end
    if (OUT_W < SYM_W) begin : g_bad_out_w
        $error("axis_sym_unpack: OUT_W must be at least SYM_W");
    end

    state_t           r_state, w_state_nx;
    logic [IN_W-1:0]  r_word, w_word_sh;
    logic             r_msb, r_tlast, r_rdy_en;
    logic [SPS_W-1:0] r_sps, r_rep, w_sps_ld, w_sps_m1, w_rep_inc;
    logic [IDX_W-1:0] r_idx, w_idx_inc;
    logic [OUT_W-1:0] r_mdata;
    logic             r_mlast;
    logic             w_active, w_beat, w_rep_end, w_last_beat, w_load;

    // The read end is the top of the word in MSB-first mode, the bottom otherwise.
    function automatic logic [OUT_W-1:0] read_end(input logic [IN_W-1:0] w, input logic msb);
        logic [SYM_W-1:0] s;
        s = msb ? w[IN_W-1 -: SYM_W] : w[SYM_W-1:0];
        return OUT_W'(s);
    endfunction

    assign w_active    = (r_state == ACTIVE);
    assign w_beat      = w_active & m_tready;
    assign w_sps_m1    = r_sps - SPS_W'(1);
    assign w_rep_end   = (r_rep == w_sps_m1);
    assign w_last_beat = w_beat & w_rep_end & (r_idx == LAST_IDX);
    assign s_tready    = r_rdy_en & (~w_active | w_last_beat);
    assign w_load      = s_tvalid & s_tready;
    assign w_sps_ld    = (cfg_sps == '0) ? SPS_W'(SPS_MIN) : cfg_sps;
    assign w_word_sh   = r_msb ? (r_word << SYM_W) : (r_word >> SYM_W);
    assign w_rep_inc   = r_rep + SPS_W'(1);
    assign w_idx_inc   = r_idx + IDX_W'(1);

    assign m_tvalid = w_active;
    assign m_tdata  = r_mdata;
    assign m_tlast  = r_mlast;
    assign busy     = w_active;

    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
        if (!axis_data_rst_n) begin
            r_state  <= IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_rdy_en <= 1'b1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_nx = ACTIVE;
            ACTIVE:  if (w_last_beat && !w_load) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // A load on the final beat takes priority so the next word follows with no bubble.
    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
        if (!axis_data_rst_n) begin
            r_word  <= '0;
            r_msb   <= MSB_FIRST;
            r_tlast <= 1'b0;
            r_sps   <= SPS_W'(SPS_MIN);
            r_rep   <= '0;
            r_idx   <= '0;
            r_mdata <= '0;
            r_mlast <= 1'b0;
        end else if (w_load) begin
            r_word  <= s_tdata;
            r_msb   <= cfg_msb_first;
            r_tlast <= s_tlast;
            r_sps   <= w_sps_ld;
            r_rep   <= '0;
            r_idx   <= '0;
            r_mdata <= read_end(s_tdata, cfg_msb_first);
            r_mlast <= s_tlast & (LAST_IDX == '0) & (w_sps_ld == SPS_W'(1));
        end else if (w_beat) begin
            if (w_last_beat) begin
                r_mdata <= '0;
                r_mlast <= 1'b0;
            end else if (w_rep_end) begin
                r_rep   <= '0;
                r_idx   <= w_idx_inc;
                r_word  <= w_word_sh;
                r_mdata <= read_end(w_word_sh, r_msb);
                r_mlast <= r_tlast & (w_idx_inc == LAST_IDX) & (r_sps == SPS_W'(1));
            end else begin
                r_rep   <= w_rep_inc;
                r_mlast <= r_tlast & (r_idx == LAST_IDX) & (w_rep_inc == w_sps_m1);
            end
        end
    end

endmodule
